// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: RV32M ALU function codes, muldiv state enum and decode helpers
package muldiv_unit_pkg;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;
  localparam int MULDIV_CNT_W = $clog2(32);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} muldiv_state_t;
  function automatic logic is_m(input logic [4:0] f);
    return f inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction
  function automatic logic is_div(input logic [4:0] f);
    return f inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction
  function automatic logic sgn_a(input logic [4:0] f);
    return f inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  endfunction
  function automatic logic sgn_b(input logic [4:0] f);
    return f inside {ALU_MULH, ALU_DIV, ALU_REM};
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring divide on {hi, lo}
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_nxt
);
  logic [XLEN:0] sum, sh, diff;
  assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign sh = acc[2*XLEN-1:XLEN-1];
  // the partial remainder stays below 2*divisor, so diff[XLEN] is exactly the borrow
  assign diff = sh - {1'b0, opnd};
  assign acc_nxt = div ? {diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0], acc[XLEN-2:0], ~diff[XLEN]}
                       : {sum, acc[XLEN-1:1]};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit
// define MULDIV_EARLY_OUT_EN to skip CALC for divide-by-zero, signed overflow and multiply by zero
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic [4:0]      alu_function,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  muldiv_state_t state;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] acc, acc_nxt, prod, init_acc, eo_acc;
  logic [XLEN-1:0] opnd, mag_a, mag_b, quo, rem, fix_res;
  logic [4:0] fn;
  logic sa, sb, bz, neg_a, neg_b, dv, fdv, accept, eo;
  assign dv = is_div(alu_function);
  assign fdv = is_div(fn);
  assign neg_a = sgn_a(alu_function) & operand_a[XLEN-1];
  assign neg_b = sgn_b(alu_function) & operand_b[XLEN-1];
  assign mag_a = neg_a ? -operand_a : operand_a;
  assign mag_b = neg_b ? -operand_b : operand_b;
  assign accept = (state == S_IDLE || state == S_DONE) && start && !kill && is_m(alu_function);
  assign init_acc = {{XLEN{1'b0}}, dv ? mag_a : mag_b};
`ifdef MULDIV_EARLY_OUT_EN
  logic ovf;
  assign ovf = sgn_b(alu_function) && operand_a == {1'b1, {(XLEN-1){1'b0}}} && &operand_b;
  assign eo = operand_b == '0 || (dv && ovf);
  // preload the accumulator with what CALC would have produced
  assign eo_acc = !dv ? '0 : operand_b == '0 ? {mag_a, {XLEN{1'b1}}}
                                             : {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
`else
  assign eo = 1'b0;
  assign eo_acc = init_acc;
`endif
  muldiv_step #(.XLEN(XLEN)) u_step (.div(fdv), .acc(acc), .opnd(opnd), .acc_nxt(acc_nxt));
  assign prod = (sa ^ sb) ? -acc : acc;
  assign quo = acc[XLEN-1:0];
  assign rem = acc[2*XLEN-1:XLEN];
  assign fix_res = fn == ALU_MUL  ? prod[XLEN-1:0] :
                   !fdv           ? prod[2*XLEN-1:XLEN] :
                   fn == ALU_DIV  ? (bz ? '1 : (sa ^ sb) ? -quo : quo) :
                   fn == ALU_DIVU ? quo :
                   fn == ALU_REM  ? (sa ? -rem : rem) : rem;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      fn <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      bz <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        fn <= alu_function;
        sa <= neg_a;
        sb <= neg_b;
        bz <= operand_b == '0;
        opnd <= dv ? mag_b : mag_a;
        acc <= eo ? eo_acc : init_acc;
        cnt <= CW'(XLEN - 1);
        state <= eo ? S_FIX : S_CALC;
        busy <= 1'b1;
      end else if (kill && busy) begin
        state <= S_IDLE;
        busy <= 1'b0;
      end else if (state == S_CALC) begin
        acc <= acc_nxt;
        cnt <= cnt - 1'b1;
        if (cnt == '0) state <= S_FIX;
      end else if (state == S_FIX) begin
        result <= fix_res;
        state <= S_DONE;
        done <= 1'b1;
        busy <= 1'b0;
      end else begin
        state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against a 64-bit arithmetic model
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, kill = 1'b0;
  logic [4:0] alu_function = '0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic busy, done;
  logic [31:0] result;
  int n_cmp = 0, n_err = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .kill(kill),
    .alu_function(alu_function), .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint r;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      ALU_MUL:    r = ua * ub;
      ALU_MULH:   r = (sa * sb) >>> 32;
      ALU_MULHSU: r = (sa * ub) >>> 32;
      ALU_MULHU:  r = (ua * ub) >> 32;
      ALU_DIV:    r = (b == 0) ? -64'sd1 : ovf ? sa : sa / sb;
      ALU_DIVU:   r = (b == 0) ? -64'sd1 : ua / ub;
      ALU_REM:    r = (b == 0) ? sa : ovf ? 64'sd0 : sa % sb;
      default:    r = (b == 0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] exp_lat(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    logic quick = (b == 0) || ((f == ALU_DIV || f == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (EARLY && quick) ? 32'd1 : 32'd33;
  endfunction

  // Called #1 after an edge with the unit idle or in DONE; returns #1 after the edge that raised done.
  task automatic op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                    output int lat, output int bc);
    start = 1'b1; alu_function = f; operand_a = a; operand_b = b;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    bc = int'(busy);
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      bc += int'(busy);
    end
  endtask

  task automatic run(input string tag, input logic [4:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    int lat, bc;
    op(f, a, b, lat, bc);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_lat"}, 32'(lat), exp_lat(f, a, b));
  endtask

  task automatic no_done(input string tag, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      @(posedge clock); #1;
      seen |= done;
    end
    chk(tag, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    int lat, bc;
    logic [31:0] last_exp;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    op(ALU_MUL, 32'd7, 32'hFFFF_FFFD, lat, bc);
    chk("mul7_res", result, 32'hFFFF_FFEB);
    chk("mul7_lat", 32'(lat), 32'd33);
    chk("mul7_busy_cycles", 32'(bc), 32'd33);
    @(posedge clock); #1;
    chk("mul7_done_pulse", {31'b0, done}, 32'd0);

    run("mulh", ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run("rem_neg", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14);
    run("remu", ALU_REMU, 32'd100, 32'd7, 32'd2);
    run("divu_0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("rem_0", ALU_REM, 32'd5, 32'd0, 32'd5);
    run("div_neg_0", ALU_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    run("rem_neg_0", ALU_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    run("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run("mul_0", ALU_MUL, 32'h1234_5678, 32'd0, 32'd0);
    @(posedge clock); #1;

    // start while busy is dropped, not queued
    start = 1'b1; alu_function = ALU_MUL; operand_a = 32'd7; operand_b = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    start = 1'b1; alu_function = ALU_DIVU; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 6;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("busy_start_res", result, 32'd21);
    chk("busy_start_lat", 32'(lat), 32'd33);
    no_done("busy_start_noqueue", 40);
    last_exp = 32'd21;

    // kill mid-CALC
    start = 1'b1; alu_function = ALU_MULHU; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    kill = 1'b1;
    @(posedge clock); #1;
    kill = 1'b0;
    chk("kill_busy", {31'b0, busy}, 32'd0);
    no_done("kill_no_done", 40);
    chk("kill_result_held", result, last_exp);
    run("after_kill", ALU_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, model(ALU_MULHU, 32'hDEAD_BEEF, 32'h1234_5678));
    @(posedge clock); #1;

    // kill with start in IDLE blocks the accept
    kill = 1'b1; start = 1'b1; alu_function = ALU_MUL; operand_a = 32'd9; operand_b = 32'd9;
    @(posedge clock); #1;
    kill = 1'b0; start = 1'b0;
    chk("kill_start_busy", {31'b0, busy}, 32'd0);
    no_done("kill_start_no_done", 40);

    // a non-M code is not accepted
    start = 1'b1; alu_function = 5'd0;
    @(posedge clock); #1;
    start = 1'b0;
    chk("non_m_busy", {31'b0, busy}, 32'd0);
    no_done("non_m_no_done", 40);

    // asynchronous reset in the middle of CALC
    start = 1'b1; alu_function = ALU_MUL; operand_a = 32'd11; operand_b = 32'd13;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    #2 reset_n = 1'b1;
    no_done("arst_no_done", 40);
    run("after_reset", ALU_MUL, 32'd11, 32'd13, 32'd143);

    // random back-to-back traffic against the model
    for (int i = 0; i < 40; i++) begin
      logic [4:0] f;
      logic [31:0] a, b;
      int sel;
      f = ALU_MUL + 5'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      sel = int'($urandom_range(0, 4));
      if (sel == 1) b = 32'd0;
      if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 3) b = $urandom_range(1, 15);
      if (sel == 4) a = {28'b0, 4'($urandom_range(0, 15))};
      run($sformatf("rnd%0d_f%0d", i, f), f, a, b, model(f, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
